mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Parametrised multicycle MIPS control unit; successor to the single-cycle controller/maindec/aludec split. A registered FSM sequences fetch, decode, execute, memory and writeback over several cycles. It handshakes with a variable-latency memory and supports 64-bit doubleword ops when XLEN=64. It sits beside the multicycle datapath, consumes the instruction register's op/funct fields, and drives all datapath enables, muxes and the ALU. It also keeps a retired-instruction counter.

Parameters:
XLEN, 32, datapath width; 32 or 64. At 32, ld/sd/dadd/dsub/daddi are illegal.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  6  instruction[31:26] from instruction register
funct  in  6  instruction[5:0]
mem_ready  in  1  memory completed the current request this cycle
mem_req  out  1  memory access request, held until mem_ready
iord  out  1  memory address select: 0=PC, 1=ALUOut
memwrite  out  1  memory write strobe (valid with mem_req)
irwrite  out  1  load instruction register
pcwrite  out  1  unconditional PC write
branch  out  1  beq compare enable
branch_ne  out  1  bne compare enable
regdst  out  1  write register select: 1=rd, 0=rt
memtoreg  out  1  writeback select: 1=memory data
regwrite  out  1  register file write
alusrca  out  1  ALU A: 0=PC, 1=rs
alusrcb  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
pcsrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
alucontrol  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
dtype  out  1  1 = 64-bit operation or doubleword memory access
illegal_op  out  1  one-cycle pulse on an undecodable instruction
retired  out  CNT_W  count of completed instructions

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, ld=110111, sd=111111, beq=000100, bne=000101, addi=001000, daddi=011000, j=000010.
- R-type funct decode:
  - 20/21 -> add
  - 22/23 -> sub
  - 24 -> and
  - 25 -> or
  - 2A -> slt
  - 2C -> add with dtype=1 (dadd)
  - 2E -> sub with dtype=1 (dsub)
  - any other funct is illegal.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP.
- Output timing: all outputs are combinational from the registered state, except the mem_ready-qualified strobes below. While reset=1, every output is 0 and retired is cleared.
- Reset mid-instruction: state -> FETCH on the next edge. No writeback and no count for the aborted instruction.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
  - irwrite and pcwrite are asserted only in the cycle mem_ready=1; that same edge moves to DECODE.
  - Otherwise FETCH holds.
- DECODE: alusrca=0, alusrcb=11, alucontrol=add (branch target precompute). Next state:
  - lw/sw/ld/sd -> MEMADR
  - R legal -> EXEC
  - addi/daddi -> IMMEX
  - beq/bne -> BRANCH
  - j -> JUMP
  - else -> FETCH with illegal_op=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, add; dtype=1 for ld/sd. Next: MEMRD for loads, MEMWR for stores.
- MEMRD: mem_req=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Waits for mem_ready, then -> FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol/dtype per funct -> ALUWB.
- ALUWB: regdst=1, regwrite=1 -> FETCH.
- IMMEX: alusrca=1, alusrcb=10, add; dtype=1 for daddi -> IMMWB.
- IMMWB: regdst=0, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. branch=1 for beq, branch_ne=1 for bne. -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Latched decode: the opcode class and funct decode are latched in DECODE and held to the end of the instruction, so op/funct changes after DECODE have no effect.
- dtype is 0 in every state not listed above.
- retired increments by 1 on the edge leaving each of:
  - MEMWB
  - MEMWR (with mem_ready)
  - ALUWB
  - IMMWB
  - BRANCH
  - JUMP
- retired wraps modulo 2^CNT_W. Illegal instructions are not counted.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- XLEN=32: ld, sd, daddi, dadd and dsub take the illegal path.

Test Plan:
- Reset held 2 cycles mid-MEMRD, then released -> outputs all 0 during reset; next cycle state FETCH with mem_req=1, iord=0, alusrcb=01; retired=0.
- add (op=0, funct=20) with mem_ready=1 in fetch -> FETCH, DECODE, EXEC, ALUWB over 4 cycles; regwrite=1, regdst=1 in ALUWB; retired=1.
- lw with mem_ready low 3 cycles in MEMRD -> mem_req=1, iord=1 held 4 cycles; then MEMWB with memtoreg=1, regwrite=1; total 5+3 cycles.
- XLEN=64, ld then dadd (funct=2C) -> dtype=1 in MEMADR/MEMRD/MEMWB and in EXEC with alucontrol=0010; XLEN=32 same op=110111 -> illegal_op pulse in DECODE, retired unchanged.
- beq then bne then j -> branch=1/branch_ne=0, then branch=0/branch_ne=1 (alucontrol=0110, pcsrc=01), then pcsrc=10 with pcwrite=1; retired +3.
- CNT_W=4, 17 addi instructions -> retired reads 1 after wrap; illegal funct 3F -> illegal_op=1 for exactly one cycle, then FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: registered FSM sequencing fetch/decode/execute/memory/writeback
// with a variable-latency memory handshake, optional 64-bit ops and a retired-instruction counter.
module mc_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             branch_ne,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [3:0]       alucontrol,
    output logic             dtype,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP
    } state_t;

    typedef enum logic [2:0] {
        CL_LOAD, CL_STORE, CL_RTYPE, CL_IMM, CL_BEQ, CL_BNE, CL_JUMP, CL_ILL
    } class_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam bit WIDE = (XLEN == 64);

    state_t             state_q, state_d;
    class_t             class_q, class_d;
    logic [3:0]         alu_q, alu_d;
    logic               dtype_q, dtype_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    class_t             dec_class;
    logic [3:0]         dec_alu;
    logic               dec_dtype;
    logic               retire;

    // Raw decode of the live instruction-register fields; only consumed in DECODE.
    always_comb begin
        dec_class = CL_ILL;
        dec_alu   = ALU_ADD;
        dec_dtype = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'h20, 6'h21: dec_class = CL_RTYPE;
                    6'h22, 6'h23: begin dec_class = CL_RTYPE; dec_alu = ALU_SUB; end
                    6'h24:        begin dec_class = CL_RTYPE; dec_alu = ALU_AND; end
                    6'h25:        begin dec_class = CL_RTYPE; dec_alu = ALU_OR;  end
                    6'h2A:        begin dec_class = CL_RTYPE; dec_alu = ALU_SLT; end
                    6'h2C: if (WIDE) begin dec_class = CL_RTYPE; dec_dtype = 1'b1; end
                    6'h2E: if (WIDE) begin
                        dec_class = CL_RTYPE;
                        dec_alu   = ALU_SUB;
                        dec_dtype = 1'b1;
                    end
                    default: dec_class = CL_ILL;
                endcase
            end
            6'b100011: dec_class = CL_LOAD;
            6'b101011: dec_class = CL_STORE;
            6'b110111: if (WIDE) begin dec_class = CL_LOAD;  dec_dtype = 1'b1; end
            6'b111111: if (WIDE) begin dec_class = CL_STORE; dec_dtype = 1'b1; end
            6'b000100: dec_class = CL_BEQ;
            6'b000101: dec_class = CL_BNE;
            6'b001000: dec_class = CL_IMM;
            6'b011000: if (WIDE) begin dec_class = CL_IMM; dec_dtype = 1'b1; end
            6'b000010: dec_class = CL_JUMP;
            default:   dec_class = CL_ILL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        alu_d   = alu_q;
        dtype_d = dtype_q;
        retire  = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                class_d = dec_class;
                alu_d   = dec_alu;
                dtype_d = dec_dtype;
                case (dec_class)
                    CL_LOAD, CL_STORE: state_d = MEMADR;
                    CL_RTYPE:          state_d = EXEC;
                    CL_IMM:            state_d = IMMEX;
                    CL_BEQ, CL_BNE:    state_d = BRANCH;
                    CL_JUMP:           state_d = JUMP;
                    default:           state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (class_q == CL_LOAD) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  begin state_d = FETCH; retire = 1'b1; end
            MEMWR:  if (mem_ready) begin state_d = FETCH; retire = 1'b1; end
            EXEC:   state_d = ALUWB;
            ALUWB:  begin state_d = FETCH; retire = 1'b1; end
            IMMEX:  state_d = IMMWB;
            IMMWB:  begin state_d = FETCH; retire = 1'b1; end
            BRANCH: begin state_d = FETCH; retire = 1'b1; end
            JUMP:   begin state_d = FETCH; retire = 1'b1; end
            default: state_d = FETCH;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            class_q   <= CL_ILL;
            alu_q     <= ALU_ADD;
            dtype_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            alu_q     <= alu_d;
            dtype_q   <= dtype_d;
            retired_q <= retired_d;
        end
    end

    // Everything is forced low while reset is asserted, including the counter view.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 4'b0000;
        dtype      = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req    = 1'b1;
                    alusrcb    = 2'b01;
                    alucontrol = ALU_ADD;
                    irwrite    = mem_ready;
                    pcwrite    = mem_ready;
                end
                DECODE: begin
                    alusrcb    = 2'b11;
                    alucontrol = ALU_ADD;
                    illegal_op = (dec_class == CL_ILL);
                end
                MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                    dtype      = dtype_q;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    dtype   = dtype_q;
                end
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                    dtype    = dtype_q;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    dtype    = dtype_q;
                end
                EXEC: begin
                    alusrca    = 1'b1;
                    alucontrol = alu_q;
                    dtype      = dtype_q;
                end
                ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                IMMEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                    dtype      = dtype_q;
                end
                IMMWB: regwrite = 1'b1;
                BRANCH: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    branch     = (class_q == CL_BEQ);
                    branch_ne  = (class_q == CL_BNE);
                end
                JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: a 64-bit/CNT_W=4 instance and a 32-bit/CNT_W=8 instance checked
// cycle by cycle against an instruction-level trace model, directed cases then random ones.
module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rdy_a, rdy_b;
    logic [5:0] op_a, funct_a, op_b, funct_b;

    logic       mem_req_a, iord_a, memwrite_a, irwrite_a, pcwrite_a, branch_a, branch_ne_a;
    logic       regdst_a, memtoreg_a, regwrite_a, alusrca_a, dtype_a, illegal_op_a;
    logic [1:0] alusrcb_a, pcsrc_a;
    logic [3:0] alucontrol_a;
    logic [3:0] retired_a;

    logic       mem_req_b, iord_b, memwrite_b, irwrite_b, pcwrite_b, branch_b, branch_ne_b;
    logic       regdst_b, memtoreg_b, regwrite_b, alusrca_b, dtype_b, illegal_op_b;
    logic [1:0] alusrcb_b, pcsrc_b;
    logic [3:0] alucontrol_b;
    logic [7:0] retired_b;

    mc_controller #(.XLEN(64), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .op(op_a), .funct(funct_a), .mem_ready(rdy_a),
        .mem_req(mem_req_a), .iord(iord_a), .memwrite(memwrite_a), .irwrite(irwrite_a),
        .pcwrite(pcwrite_a), .branch(branch_a), .branch_ne(branch_ne_a), .regdst(regdst_a),
        .memtoreg(memtoreg_a), .regwrite(regwrite_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
        .pcsrc(pcsrc_a), .alucontrol(alucontrol_a), .dtype(dtype_a), .illegal_op(illegal_op_a),
        .retired(retired_a)
    );

    mc_controller #(.XLEN(32), .CNT_W(8)) dut_b (
        .clk(clk), .reset(rst_b), .op(op_b), .funct(funct_b), .mem_ready(rdy_b),
        .mem_req(mem_req_b), .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
        .pcwrite(pcwrite_b), .branch(branch_b), .branch_ne(branch_ne_b), .regdst(regdst_b),
        .memtoreg(memtoreg_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
        .pcsrc(pcsrc_b), .alucontrol(alucontrol_b), .dtype(dtype_b), .illegal_op(illegal_op_b),
        .retired(retired_b)
    );

    logic [20:0] obs_a, obs_b;
    assign obs_a = {mem_req_a, iord_a, memwrite_a, irwrite_a, pcwrite_a, branch_a, branch_ne_a,
                    regdst_a, memtoreg_a, regwrite_a, alusrca_a, alusrcb_a, pcsrc_a,
                    alucontrol_a, dtype_a, illegal_op_a};
    assign obs_b = {mem_req_b, iord_b, memwrite_b, irwrite_b, pcwrite_b, branch_b, branch_ne_b,
                    regdst_b, memtoreg_b, regwrite_b, alusrca_b, alusrcb_b, pcsrc_b,
                    alucontrol_b, dtype_b, illegal_op_b};

    int checks = 0;
    int errors = 0;
    int count_a = 0;
    int count_b = 0;

    // Output bundle in the same field order as obs_a/obs_b.
    function automatic logic [20:0] mk(input logic mreq, io, mw, irw, pcw, br, bne, rdst, m2r, rw,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] pcs,
                                       input logic [3:0] alu, input logic dt, input logic ill);
        return {mreq, io, mw, irw, pcw, br, bne, rdst, m2r, rw, sa, sb, pcs, alu, dt, ill};
    endfunction

    // Instruction-level reference: kind 0=illegal 1=load 2=store 3=R 4=imm 5=beq 6=bne 7=j.
    function automatic void decodeModel(input logic [5:0] o, input logic [5:0] f, input bit wide,
                                        output int kind, output logic [3:0] alu, output logic dw);
        kind = 0;
        alu  = 4'b0010;
        dw   = 1'b0;
        if (o == 6'b000000) begin
            if (f == 6'h20 || f == 6'h21) kind = 3;
            else if (f == 6'h22 || f == 6'h23) begin kind = 3; alu = 4'b0110; end
            else if (f == 6'h24) begin kind = 3; alu = 4'b0000; end
            else if (f == 6'h25) begin kind = 3; alu = 4'b0001; end
            else if (f == 6'h2A) begin kind = 3; alu = 4'b0111; end
            else if (f == 6'h2C && wide) begin kind = 3; dw = 1'b1; end
            else if (f == 6'h2E && wide) begin kind = 3; alu = 4'b0110; dw = 1'b1; end
        end
        else if (o == 6'b100011) kind = 1;
        else if (o == 6'b101011) kind = 2;
        else if (o == 6'b110111 && wide) begin kind = 1; dw = 1'b1; end
        else if (o == 6'b111111 && wide) begin kind = 2; dw = 1'b1; end
        else if (o == 6'b000100) kind = 5;
        else if (o == 6'b000101) kind = 6;
        else if (o == 6'b001000) kind = 4;
        else if (o == 6'b011000 && wide) begin kind = 4; dw = 1'b1; end
        else if (o == 6'b000010) kind = 7;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one DUT at the falling edge; the idle DUT is parked in FETCH with mem_ready low.
    task automatic applyStimulus(input bit sel, input logic [5:0] o, input logic [5:0] f,
                                 input logic rdy, input logic rst);
        @(negedge clk);
        if (sel) begin
            op_b = o; funct_b = f; rdy_b = rdy; rst_b = rst; rdy_a = 1'b0;
        end else begin
            op_a = o; funct_a = f; rdy_a = rdy; rst_a = rst; rdy_b = 1'b0;
        end
        #1;
    endtask

    task automatic step(input bit sel, input logic [5:0] o, input logic [5:0] f, input logic rdy,
                        input logic rst, input logic [20:0] expv, input string tag);
        applyStimulus(sel, o, f, rdy, rst);
        checkOutput(tag, {11'd0, (sel ? obs_b : obs_a)}, {11'd0, expv});
    endtask

    function automatic logic [31:0] expRetired(input bit sel);
        return sel ? 32'(count_b % 256) : 32'(count_a % 16);
    endfunction

    function automatic logic [31:0] obsRetired(input bit sel);
        return sel ? {24'd0, retired_b} : {28'd0, retired_a};
    endfunction

    task automatic runInstr(input bit sel, input logic [5:0] o, input logic [5:0] f,
                            input int fwait, input int mwait, input string name);
        int         kind;
        logic [3:0] alu;
        logic       dw;
        logic [20:0] v;
        decodeModel(o, f, !sel, kind, alu, dw);
        for (int i = 0; i < fwait; i++) begin
            step(sel, o, f, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0), {name, "_fetchwait"});
            if (i == 0) checkOutput({name, "_retired"}, obsRetired(sel), expRetired(sel));
        end
        step(sel, o, f, 1'b1, 1'b0, mk(1,0,0,1,1,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0), {name, "_fetch"});
        if (fwait == 0) checkOutput({name, "_retired"}, obsRetired(sel), expRetired(sel));
        step(sel, o, f, 1'($urandom), 1'b0,
             mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,(kind == 0)), {name, "_decode"});
        if (kind == 0) return;
        case (kind)
            1, 2: begin
                step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                     mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,dw,0), {name, "_memadr"});
                v = (kind == 1) ? mk(1,1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0000,dw,0)
                                : mk(1,1,1,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0000,dw,0);
                for (int i = 0; i < mwait; i++)
                    step(sel, 6'($urandom), 6'($urandom), 1'b0, 1'b0, v, {name, "_memwait"});
                step(sel, 6'($urandom), 6'($urandom), 1'b1, 1'b0, v, {name, "_memdone"});
                if (kind == 1)
                    step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                         mk(0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0000,dw,0), {name, "_memwb"});
            end
            3: begin
                step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                     mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,alu,dw,0), {name, "_exec"});
                step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                     mk(0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,4'b0000,0,0), {name, "_aluwb"});
            end
            4: begin
                step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                     mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,dw,0), {name, "_immex"});
                step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                     mk(0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,4'b0000,0,0), {name, "_immwb"});
            end
            5, 6: step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                       mk(0,0,0,0,0,(kind == 5),(kind == 6),0,0,0,1,2'b00,2'b01,4'b0110,0,0),
                       {name, "_branch"});
            default: step(sel, 6'($urandom), 6'($urandom), 1'($urandom), 1'b0,
                          mk(0,0,0,0,1,0,0,0,0,0,0,2'b00,2'b10,4'b0000,0,0), {name, "_jump"});
        endcase
        if (sel) count_b++; else count_a++;
    endtask

    logic [5:0] op_list [11] = '{6'h00, 6'h23, 6'h2B, 6'h37, 6'h3F, 6'h04, 6'h05, 6'h08, 6'h18, 6'h02, 6'h3E};
    logic [5:0] fn_list [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2C, 6'h2E, 6'h3F, 6'h00};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        op_a = '0; funct_a = '0; op_b = '0; funct_b = '0;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checkOutput("reset_outs_a", {11'd0, obs_a}, 32'd0);
            checkOutput("reset_outs_b", {11'd0, obs_b}, 32'd0);
            checkOutput("reset_ret_a", {28'd0, retired_a}, 32'd0);
            checkOutput("reset_ret_b", {24'd0, retired_b}, 32'd0);
        end
        rst_b = 1'b0;

        runInstr(0, 6'h00, 6'h20, 0, 0, "add");
        runInstr(0, 6'h23, 6'h00, 1, 3, "lw");
        runInstr(0, 6'h37, 6'h00, 0, 2, "ld64");
        runInstr(0, 6'h00, 6'h2C, 0, 0, "dadd64");
        runInstr(0, 6'h3F, 6'h00, 2, 1, "sd64");
        runInstr(0, 6'h04, 6'h00, 0, 0, "beq");
        runInstr(0, 6'h05, 6'h00, 0, 0, "bne");
        runInstr(0, 6'h02, 6'h00, 0, 0, "j");
        runInstr(0, 6'h00, 6'h3F, 0, 0, "badfunct");
        runInstr(1, 6'h37, 6'h00, 0, 0, "ld32");
        runInstr(1, 6'h00, 6'h2E, 0, 0, "dsub32");
        runInstr(1, 6'h18, 6'h00, 0, 0, "daddi32");
        runInstr(1, 6'h00, 6'h2A, 1, 0, "slt32");

        // Abort a load in MEMRD with a two-cycle reset.
        step(0, 6'h23, 6'h00, 1'b1, 1'b0, mk(1,0,0,1,1,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0), "abort_fetch");
        step(0, 6'h23, 6'h00, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,4'b0010,0,0), "abort_decode");
        step(0, 6'h23, 6'h00, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0010,0,0), "abort_memadr");
        step(0, 6'h23, 6'h00, 1'b0, 1'b0, mk(1,1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0000,0,0), "abort_memrd");
        step(0, 6'h23, 6'h00, 1'b1, 1'b1, 21'd0, "abort_reset1");
        checkOutput("abort_ret1", {28'd0, retired_a}, 32'd0);
        step(0, 6'h23, 6'h00, 1'b1, 1'b1, 21'd0, "abort_reset2");
        count_a = 0;
        step(0, 6'h23, 6'h00, 1'b0, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,4'b0010,0,0), "abort_refetch");
        checkOutput("abort_ret0", {28'd0, retired_a}, 32'd0);

        for (int i = 0; i < 17; i++)
            runInstr(0, 6'h08, 6'h00, 0, 0, "addi");
        applyStimulus(0, 6'h00, 6'h00, 1'b0, 1'b0);
        checkOutput("wrap_ret", {28'd0, retired_a}, 32'd1);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] o, f;
            o = op_list[$urandom_range(0, 10)];
            f = fn_list[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            runInstr(i[0], o, f, $urandom_range(0, 2), $urandom_range(0, 3), "rand");
        end
        applyStimulus(0, 6'h00, 6'h00, 1'b0, 1'b0);
        checkOutput("final_ret_a", obsRetired(0), expRetired(0));
        checkOutput("final_ret_b", obsRetired(1), expRetired(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
